// File: rtl/bus_pkg.sv
// Shared system-bus definitions for the memory responder: tag layout, line geometry, FSM states.
// Optional macro BUS_RESP_WRITE_ACK_EN adds the WACK state for write responses.
package bus_pkg;

    localparam int unsigned TAG_WR_BIT  = 12;
    localparam int unsigned TAG_TYPE_HI = 11;
    localparam int unsigned TAG_TYPE_LO = 8;
    localparam int unsigned TAG_ID_HI   = 7;
    localparam int unsigned TAG_ID_LO   = 0;

    // Target types; anything other than MEMORY is still serviced as memory.
    localparam logic [3:0] TARGET_MEMORY = 4'h1;

    localparam int unsigned BEATS  = 8;
    localparam int unsigned BEAT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        RWAIT,
`ifdef BUS_RESP_WRITE_ACK_EN
        RBURST,
        WACK
`else
        RBURST
`endif
    } state_t;

    // Word within the line for a critical-word-first beat; wraps modulo BEATS.
    function automatic logic [BEAT_W-1:0] line_word(input logic [BEAT_W-1:0] offset,
                                                   input logic [BEAT_W-1:0] beat);
        return offset + beat;
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Backing word array for the bus memory responder: whole-line synchronous write,
// single-word registered read.
module bus_mem_array #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned WORDS      = 4096,
    parameter int unsigned BEATS      = 8
) (
    input  logic                                        clk,
    input  logic                                        line_we,
    input  logic [$clog2(WORDS)-$clog2(BEATS)-1:0]      line_idx,
    input  logic [BEATS-1:0][DATA_WIDTH-1:0]            line_data,
    input  logic [$clog2(WORDS)-1:0]                    rd_addr,
    output logic [DATA_WIDTH-1:0]                       rd_data
);

    localparam int unsigned BW = $clog2(BEATS);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // A line is committed in one edge so an aborted burst never leaves a partial line.
    always_ff @(posedge clk) begin
        if (line_we) begin
            for (int unsigned i = 0; i < BEATS; i++) begin
                mem[{line_idx, BW'(i)}] <= line_data[i];
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side system-bus responder: 8-beat line writes, critical-word-first 8-beat reads.
// Optional macro BUS_RESP_WRITE_ACK_EN: one zero-data response beat after each write commit.
module bus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4,
    parameter int unsigned BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    output logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    import bus_pkg::*;

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned BW    = $clog2(BEATS);
    localparam int unsigned IW    = BUS_DATA_WIDTH - 3;
    localparam int unsigned LAT_W = $clog2(READ_LATENCY) + 1;
    localparam logic [IW-1:0] WORD_LIMIT = IW'(MEM_WORDS);

    state_t                             state_q, state_d;
    logic [AW-1:0]                      idx_q, idx_d;
    logic [BUS_TAG_WIDTH-1:0]           tag_d;
    logic                               oor_q, oor_d;
    logic [BW-1:0]                      beat_q, beat_d;
    logic [LAT_W-1:0]                   lat_q, lat_d;
    logic                               respcyc_d;
    logic [BUS_DATA_WIDTH-1:0]          resp_d;

    logic [BUS_DATA_WIDTH-1:0]          wbuf [BEATS];
    logic                               cap_en;
    logic                               line_we;
    logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] line_data;
    logic [AW-1:0]                      rd_addr;
    logic [BUS_DATA_WIDTH-1:0]          rd_data;

    logic [AW-1:0]                      req_idx;
    logic                               req_oor;
    logic                               resp_fire;

    assign req_idx    = bus_req[AW+2:3];
    assign req_oor    = bus_req[BUS_DATA_WIDTH-1:3] >= WORD_LIMIT;
    assign resp_fire  = bus_respcyc && bus_respack;
    assign bus_reqack = bus_reqcyc && (state_q == IDLE || state_q == WDATA);

    // The final beat goes straight from the bus into the line, so the commit needs no extra cycle.
    always_comb begin
        for (int unsigned i = 0; i < BEATS; i++) begin
            line_data[i] = (i == BEATS - 1) ? bus_req : wbuf[i];
        end
    end

    // The array read port runs one beat ahead of bus_resp, so the next beat is ready when
    // the current one is acked; in IDLE it reads the requested word directly off the bus.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tag_d     = bus_resptag;
        oor_d     = oor_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        respcyc_d = bus_respcyc;
        resp_d    = bus_resp;
        cap_en    = 1'b0;
        line_we   = 1'b0;
        rd_addr   = req_idx;

        case (state_q)
            IDLE: begin
                if (bus_reqcyc) begin
                    idx_d  = req_idx;
                    tag_d  = bus_reqtag;
                    oor_d  = req_oor;
                    beat_d = '0;
                    if (bus_reqtag[TAG_WR_BIT]) begin
                        state_d = WDATA;
                    end else begin
                        state_d = RWAIT;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                    end
                end
            end

            WDATA: begin
                if (bus_reqcyc) begin
                    cap_en = 1'b1;
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(BEATS - 1)) begin
                        line_we = !oor_q;
                        beat_d  = '0;
`ifdef BUS_RESP_WRITE_ACK_EN
                        state_d   = WACK;
                        respcyc_d = 1'b1;
                        resp_d    = '0;
`else
                        state_d   = IDLE;
`endif
                    end
                end
            end

            RWAIT: begin
                if (lat_q == '0) begin
                    rd_addr   = {idx_q[AW-1:BW], line_word(idx_q[BW-1:0], BW'(1))};
                    state_d   = RBURST;
                    respcyc_d = 1'b1;
                    resp_d    = oor_q ? '0 : rd_data;
                    beat_d    = '0;
                end else begin
                    rd_addr = idx_q;
                    lat_d   = lat_q - LAT_W'(1);
                end
            end

            RBURST: begin
                rd_addr = {idx_q[AW-1:BW],
                           line_word(idx_q[BW-1:0], beat_q + (resp_fire ? BW'(2) : BW'(1)))};
                if (resp_fire) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                        resp_d    = '0;
                        beat_d    = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                        resp_d = oor_q ? '0 : rd_data;
                    end
                end
            end

`ifdef BUS_RESP_WRITE_ACK_EN
            WACK: begin
                if (resp_fire) begin
                    state_d   = IDLE;
                    respcyc_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            oor_q       <= 1'b0;
            beat_q      <= '0;
            lat_q       <= '0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            oor_q       <= oor_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            bus_respcyc <= respcyc_d;
            bus_resp    <= resp_d;
            bus_resptag <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            wbuf[beat_q] <= bus_req;
        end
    end

    bus_mem_array #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .WORDS      (MEM_WORDS),
        .BEATS      (BEATS)
    ) u_array (
        .clk       (clk),
        .line_we   (line_we),
        .line_idx  (idx_q[AW-1:BW]),
        .line_data (line_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder against a word-array model of the memory.
// Define BUS_RESP_WRITE_ACK_EN to also exercise the write-response beat.
module tb_bus_mem_responder;

    localparam int unsigned WORDS = 4096;
    localparam int unsigned LAT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqcyc;
    logic        respack;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        respcyc;
    logic        reqack;
    logic [63:0] resp;
    logic [12:0] resptag;

    int checks = 0;
    int errors = 0;

    logic [63:0]  mdl [int unsigned];
    logic [63:0]  wd [8];
    int unsigned  stall [8];
    int unsigned  written_lines [$];
    bit           noisy = 1'b0;

    always #5 clk = ~clk;

    bus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (WORDS),
        .READ_LATENCY   (LAT),
        .BEATS          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (reqcyc),
        .bus_respack (respack),
        .bus_req     (req),
        .bus_reqtag  (reqtag),
        .bus_respcyc (respcyc),
        .bus_reqack  (reqack),
        .bus_resp    (resp),
        .bus_resptag (resptag)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Beat i of a read: word (offset + i) mod 8 of the addressed line, 0 when out of range.
    function automatic logic [63:0] exp_word(input logic [63:0] addr, input int unsigned i);
        logic [63:0] idx;
        int unsigned base;
        int unsigned w;
        idx = addr >> 3;
        if (idx >= 64'(WORDS)) return '0;
        base = 32'(idx) & ~32'd7;
        w = base + ((32'(idx) + i) % 8);
        if (!mdl.exists(w)) return 'x;
        return mdl[w];
    endfunction

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input int unsigned max_gap);
        reqcyc = 1'b1; req = addr; reqtag = tag;
        @(negedge clk);
        checks++;
        if (reqack !== 1'b1) begin
            errors++; $display("FAIL wr_addr_ack addr=%h got=%b exp=1", addr, reqack);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            int unsigned gap;
            gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
            repeat (gap) begin
                reqcyc = 1'b0; req = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            reqcyc = 1'b1; req = wd[i];
            @(negedge clk);
            checks++;
            if (reqack !== 1'b1) begin
                errors++; $display("FAIL wr_beat_ack addr=%h beat=%0d got=%b exp=1", addr, i, reqack);
            end
            @(posedge clk); #1;
        end
        reqcyc = 1'b0;
        if ((addr >> 3) < 64'(WORDS)) begin
            int unsigned base;
            base = 32'(addr >> 3) & ~32'd7;
            for (int unsigned i = 0; i < 8; i++) mdl[base + i] = wd[i];
            written_lines.push_back(base / 8);
        end
`ifdef BUS_RESP_WRITE_ACK_EN
        begin
            int unsigned n;
            n = 0;
            reqcyc = 1'b1; req = 64'h0; reqtag = 13'h0001;
            while (respcyc !== 1'b1 && n < 16) begin
                @(posedge clk); #1; n++;
            end
            @(negedge clk);
            checks++;
            if (respcyc !== 1'b1 || resp !== 64'h0 || resptag !== tag) begin
                errors++;
                $display("FAIL wack_beat got cyc=%b data=%h tag=%h exp cyc=1 data=0 tag=%h", respcyc, resp, resptag, tag);
            end
            checks++;
            if (reqack !== 1'b0) begin
                errors++; $display("FAIL wack_block got reqack=%b exp=0", reqack);
            end
            @(posedge clk); #1;
            respack = 1'b1;
            @(negedge clk);
            checks++;
            if (reqack !== 1'b0 || respcyc !== 1'b1) begin
                errors++; $display("FAIL wack_hold got reqack=%b cyc=%b exp reqack=0 cyc=1", reqack, respcyc);
            end
            @(posedge clk); #1;
            respack = 1'b0; reqcyc = 1'b0;
        end
`endif
        checks++;
        if (respcyc !== 1'b0) begin
            errors++; $display("FAIL wr_no_resp got respcyc=%b exp=0", respcyc);
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag);
        int unsigned lat;
        logic [63:0] e;
        lat = 0;
        reqcyc = 1'b1; req = addr; reqtag = tag; respack = 1'b0;
        @(negedge clk);
        checks++;
        if (reqack !== 1'b1) begin
            errors++; $display("FAIL rd_addr_ack addr=%h got=%b exp=1", addr, reqack);
        end
        @(posedge clk); #1;
        reqcyc = 1'b0;
        while (respcyc !== 1'b1 && lat < 32) begin
            if (noisy) begin
                reqcyc  = 1'($urandom_range(1, 0));
                req     = {$urandom, $urandom};
                respack = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            if (reqcyc) begin
                checks++;
                if (reqack !== 1'b0) begin
                    errors++; $display("FAIL rwait_no_ack got=%b exp=0", reqack);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (respcyc !== 1'b1 || lat != LAT) begin
            errors++;
            $display("FAIL rd_latency addr=%h got=%0d edges (cyc=%b) exp=%0d", addr, lat, respcyc, LAT);
            reqcyc = 1'b0; respack = 1'b0;
            return;
        end
        for (int unsigned i = 0; i < 8; i++) begin
            e = exp_word(addr, i);
            for (int unsigned s = 0; s < stall[i]; s++) begin
                respack = 1'b0;
                if (noisy) begin
                    reqcyc = 1'($urandom_range(1, 0));
                    req    = {$urandom, $urandom};
                end
                @(negedge clk);
                checks++;
                if (respcyc !== 1'b1 || resp !== e) begin
                    errors++;
                    $display("FAIL rd_stall_hold addr=%h beat=%0d got cyc=%b data=%h exp cyc=1 data=%h", addr, i, respcyc, resp, e);
                end
                if (reqcyc) begin
                    checks++;
                    if (reqack !== 1'b0) begin
                        errors++; $display("FAIL rburst_no_ack got=%b exp=0", reqack);
                    end
                end
                @(posedge clk); #1;
            end
            reqcyc = 1'b0; respack = 1'b1;
            @(negedge clk);
            checks++;
            if (respcyc !== 1'b1 || resp !== e) begin
                errors++;
                $display("FAIL rd_beat addr=%h beat=%0d got cyc=%b data=%h exp cyc=1 data=%h", addr, i, respcyc, resp, e);
            end
            checks++;
            if (resptag !== tag) begin
                errors++; $display("FAIL rd_tag addr=%h beat=%0d got=%h exp=%h", addr, i, resptag, tag);
            end
            @(posedge clk); #1;
        end
        respack = 1'b0;
        checks++;
        if (respcyc !== 1'b0) begin
            errors++; $display("FAIL rd_end addr=%h got respcyc=%b exp=0", addr, respcyc);
        end
    endtask

    task automatic clear_stalls;
        for (int i = 0; i < 8; i++) stall[i] = 0;
    endtask

    task automatic test_reset;
        int unsigned n;
        reset = 1'b0; reqcyc = 1'b0; respack = 1'b0; req = '0; reqtag = '0;
        #1;
        checks++;
        if (respcyc !== 1'b0 || reqack !== 1'b0 || resp !== 64'h0 || resptag !== 13'h0) begin
            errors++;
            $display("FAIL reset_state got cyc=%b ack=%b data=%h tag=%h exp all 0", respcyc, reqack, resp, resptag);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        do_write(64'h40, 13'h1101, 0);

        // Abort a read in the middle of its burst.
        reqcyc = 1'b1; req = 64'h40; reqtag = 13'h0102;
        @(posedge clk); #1;
        reqcyc = 1'b0;
        n = 0;
        while (respcyc !== 1'b1 && n < 32) begin
            @(posedge clk); #1; n++;
        end
        respack = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        respack = 1'b0;
        checks++;
        if (respcyc !== 1'b1) begin
            errors++; $display("FAIL reset_burst_start got respcyc=%b exp=1", respcyc);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (respcyc !== 1'b0 || resp !== 64'h0 || resptag !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_burst got cyc=%b data=%h tag=%h exp all 0", respcyc, resp, resptag);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Abort a write after three beats; the line must keep its old contents.
        reqcyc = 1'b1; req = 64'h40; reqtag = 13'h1103;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            req = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        reqcyc = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        do_read(64'h40, 13'h0105);
    endtask

    task automatic test_write_read;
        for (int i = 0; i < 8; i++) wd[i] = 64'hA0 + 64'(i);
        do_write(64'h1000, 13'h1103, 0);
        do_read(64'h1000, 13'h0103);
    endtask

    task automatic test_wrap;
        do_read(64'h1028, 13'h0104);
        do_read(64'h103F, 13'h0108);
    endtask

    task automatic test_backpressure;
        stall[2] = 3;
        do_read(64'h1000, 13'h0106);
        clear_stalls();
    endtask

    task automatic test_out_of_range;
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        do_write(64'h0, 13'h1101, 0);
        do_read(64'h8000, 13'h0107);
        do_read(64'hFFFF_0000_0000_0040, 13'h0109);
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        do_write(64'h8000, 13'h1108, 0);
        do_read(64'h0, 13'h010A);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        do_write(64'h2040, 13'h11F0, 0);
        do_read(64'h2058, 13'h01F1);
        do_read(64'h2040, 13'h02F2);
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        do_write(64'h2040, 13'h13F3, 0);
        do_write(64'h2080, 13'h14F4, 0);
        do_read(64'h2040, 13'h05F5);
    endtask

    task automatic test_random;
        logic [63:0] addr;
        logic [12:0] tag;
        noisy = 1'b1;
        for (int op = 0; op < 40; op++) begin
            if (written_lines.size() == 0 || $urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
                if ($urandom_range(7, 0) == 0)
                    addr = 64'h8000 + 64'($urandom_range(32'hFFFF, 0));
                else
                    addr = 64'($urandom_range(511, 0)) * 64 + 64'($urandom_range(63, 0));
                tag = {1'b1, 4'($urandom_range(15, 0)), 8'($urandom)};
                do_write(addr, tag, 2);
            end else begin
                if ($urandom_range(7, 0) == 0)
                    addr = 64'h8000 + 64'($urandom_range(32'hFFFF, 0));
                else
                    addr = 64'(written_lines[$urandom_range(written_lines.size() - 1, 0)]) * 64
                           + 64'($urandom_range(63, 0));
                tag = {1'b0, 4'($urandom_range(15, 0)), 8'($urandom)};
                for (int i = 0; i < 8; i++) stall[i] = $urandom_range(2, 0);
                do_read(addr, tag);
                clear_stalls();
            end
        end
        noisy = 1'b0;
    endtask

    initial begin
        clear_stalls();
        test_reset();
        test_write_read();
        test_wrap();
        test_backpressure();
        test_out_of_range();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the core's system bus; the opposite end of the requester path behind the bus arbiter.
- Accepts address/tag requests, then either collects 8-beat write bursts or returns 8-beat read bursts with the tag echoed.
- Backed by an internal word array. Used as the simulation/FPGA memory target for fetch and mm-stage traffic.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp
- BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag
- MEM_WORDS, 4096, number of 64-bit words in the backing array (multiple of 8)
- READ_LATENCY, 4, clock edges from address acceptance to first read beat (>=1)
- BEATS, 8, data beats per line (64-byte line)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- bus_reqcyc  input  1  request beat valid
- bus_respack  input  1  response beat consumed
- bus_req  input  BUS_DATA_WIDTH  address beat, then write data beats
- bus_reqtag  input  BUS_TAG_WIDTH  request tag, sampled on the address beat only
- bus_respcyc  output  1  response beat valid
- bus_reqack  output  1  request beat accepted this cycle
- bus_resp  output  BUS_DATA_WIDTH  read data beat
- bus_resptag  output  BUS_TAG_WIDTH  echoed request tag

Behaviour:
- Reset (reset low, async):
  - All outputs 0; state IDLE; counters 0.
  - Array contents are not cleared.
  - An in-flight burst is aborted and a partial write is discarded.
- Tag fields:
  - tag[12]=WR (1 write, 0 read).
  - tag[11:8]=target type; MEMORY=4'h1, other types are still serviced as memory.
  - tag[7:0]=requester id.
  - The full tag is echoed unchanged.
- Addressing:
  - Word index = bus_req[..:3]; addr[2:0] ignored.
  - Line base word = index with low 3 bits cleared.
  - Index >= MEM_WORDS is out of range: reads return 0 and writes are dropped. Handshake is unchanged.
- bus_reqack is combinational: bus_reqcyc && (state==IDLE || state==WDATA). All other outputs are registered.
- FSM states: IDLE, WDATA, RWAIT, RBURST (plus WACK, see Optional Feature).
- IDLE:
  - On an edge with reqcyc high, latch addr/tag.
  - WR=1 -> WDATA with beat_cnt=0.
  - WR=0 -> RWAIT with lat_cnt=READ_LATENCY-1.
- WDATA:
  - Each edge with reqcyc high captures bus_req into line word beat_cnt. Write order is line-aligned, not wrapped.
  - beat_cnt increments; after beat 7 the line commits -> IDLE.
  - reqcyc low: no capture, wait indefinitely.
- RWAIT:
  - lat_cnt decrements each edge; at 0 -> RBURST with beat 0 loaded onto bus_resp and respcyc=1.
  - The first beat is visible exactly READ_LATENCY edges after the accepting edge.
- RBURST:
  - Beats are critical-word-first with wrap: beat i = line word (addr[5:3]+i) mod 8.
  - A beat is held stable until an edge with respcyc && respack, then the next beat is presented.
  - After beat 7 is acked, respcyc=0 next cycle -> IDLE.
- Boundary conditions:
  - respack while respcyc=0 is ignored.
  - reqcyc during RWAIT/RBURST is not acked; the requester holds.
  - A new request is acceptable in the cycle right after return to IDLE (back-to-back).
  - A read of a line written by the immediately preceding burst returns the new data.

Optional Feature:
- Macro BUS_RESP_WRITE_ACK_EN.
- Defined: after the write commit, enter WACK and drive one response beat (respcyc=1, bus_resp=0, bus_resptag=write tag) until respack, then IDLE.
- Undefined: writes produce no response; WDATA -> IDLE directly; the WACK state is absent.

Decomposition:
- Shared package bus_pkg:
  - Tag field positions, WR bit index.
  - Target-type constants (MEMORY=4'h1).
  - BEATS, the state enum, and the line-offset helper function.
- One sub-module: bus_mem_array (synchronous-write, registered-read word array, MEM_WORDS x BUS_DATA_WIDTH). FSM and counters stay in the top.

Test Plan:
- Reset:
  - Assert reset low mid-RBURST -> respcyc=0 immediately.
  - Release and issue a read of 0x40 with tag 0x0105 -> full 8-beat burst with resptag 0x0105.
- Write then read:
  - Write 0x1000 tag 0x1103, data 0xA0..0xA7 -> reqack on all 9 beats.
  - Read 0x1000 -> beats 0xA0..0xA7, first beat 4 edges after acceptance.
- Critical-word wrap: read 0x1028 -> beats 0xA5,0xA6,0xA7,0xA0,0xA1,0xA2,0xA3,0xA4.
- Backpressure: hold respack low 3 cycles on beat 2 -> bus_resp stays 0xA2; no beat skipped or duplicated.
- Out of range: with MEM_WORDS=4096, read 0x8000 -> 8 beats of 0; write 0x8000 then read 0x0 -> contents unchanged.
- Optional feature (BUS_RESP_WRITE_ACK_EN defined): write tag 0x1107 -> single respcyc beat, bus_resp=0, resptag=0x1107; a concurrent reqcyc is not acked until that beat is acked.
